// File: rtl/core_ldst_seq.sv
// Load/store sequencer: single byte/half/word transfers and multi-register block
// transfers, one outstanding memory request at a time.
module core_ldst_seq #(
    parameter int WIDTH  = 32,
    parameter int NREGS  = 16,
    parameter int RIDX_W = $clog2(NREGS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 write,
    input  logic [1:0]           size,
    input  logic                 sign_ext,
    input  logic [WIDTH-1:0]     base,
    input  logic [NREGS-1:0]     reg_mask,
    input  logic [RIDX_W-1:0]    single_reg,
    input  logic                 decr,
    input  logic                 pre,
    output logic [RIDX_W-1:0]    rd_idx,
    input  logic [WIDTH-1:0]     rd_value,
    output logic                 wr_en,
    output logic [RIDX_W-1:0]    wr_idx,
    output logic [WIDTH-1:0]     wr_value,
    output logic [WIDTH-3:0]     mem_addr,
    output logic [WIDTH-1:0]     mem_data_wr,
    output logic [WIDTH/8-1:0]   mem_data_be,
    output logic                 mem_start,
    output logic                 mem_write,
    input  logic                 mem_ready,
    input  logic [WIDTH-1:0]     mem_data_rd,
    output logic                 busy,
    output logic                 done,
    output logic                 fault,
    output logic [WIDTH-1:0]     final_addr
);

    localparam int BE_W  = WIDTH / 8;
    localparam int CNT_W = RIDX_W + 1;
    localparam logic [WIDTH-1:0] STEP = WIDTH'(4);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    state_t              state, state_nxt;
    logic                write_r, sext_r, fault_r;
    logic [1:0]          size_r;
    logic [WIDTH-1:0]    addr_r, final_r, data_hold;
    logic [NREGS-1:0]    mask_r;

    logic                accept, misaligned, empty_blk, last, active;
    logic [RIDX_W-1:0]   cur_idx;
    logic [WIDTH-1:0]    n4, blk_first, blk_final;

    function automatic logic [CNT_W-1:0] popcount(input logic [NREGS-1:0] m);
        logic [CNT_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < NREGS; i++) cnt = cnt + CNT_W'(m[i]);
        return cnt;
    endfunction

    function automatic logic [RIDX_W-1:0] lowest_idx(input logic [NREGS-1:0] m);
        logic [RIDX_W-1:0] idx;
        idx = '0;
        for (int i = NREGS - 1; i >= 0; i--) if (m[i]) idx = RIDX_W'(i);
        return idx;
    endfunction

    // Narrow stores replicate the low byte/half across every lane.
    function automatic logic [WIDTH-1:0] store_fmt(input logic [1:0] sz, input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        for (int i = 0; i < WIDTH; i++) begin
            case (sz)
                2'd0:    r[i] = v[i % 8];
                2'd1:    r[i] = v[i % 16];
                default: r[i] = v[i];
            endcase
        end
        return r;
    endfunction

    function automatic logic [WIDTH-1:0] load_fmt(input logic [1:0] sz, input logic sx,
                                                  input logic [1:0] lane, input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] sh_b, sh_h, r;
        sh_b = v >> {lane, 3'b000};
        sh_h = v >> {lane[1], 4'b0000};
        case (sz)
            2'd0:    r = sx ? WIDTH'($signed(sh_b[7:0]))  : WIDTH'(sh_b[7:0]);
            2'd1:    r = sx ? WIDTH'($signed(sh_h[15:0])) : WIDTH'(sh_h[15:0]);
            default: r = v;
        endcase
        return r;
    endfunction

    function automatic logic [BE_W-1:0] be_fmt(input logic [1:0] sz, input logic [1:0] lane);
        logic [BE_W-1:0] r;
        case (sz)
            2'd0:    r = BE_W'(1) << lane;
            2'd1:    r = BE_W'(3) << {lane[1], 1'b0};
            default: r = {BE_W{1'b1}};
        endcase
        return r;
    endfunction

    assign accept     = (state == S_IDLE) && start;
    assign misaligned = (size == 2'd1) ? base[0] : ((size[1] == 1'b1) && (base[1:0] != 2'b00));
    assign empty_blk  = (size == 2'd3) && (reg_mask == '0);
    assign n4         = WIDTH'(popcount(reg_mask)) << 2;
    // Descending blocks start at the lowest address too, so registers still go out in ascending order.
    assign blk_first  = decr ? (pre ? base - n4 : base - n4 + STEP) : (pre ? base + STEP : base);
    assign blk_final  = decr ? base - n4 : base + n4;
    assign cur_idx    = lowest_idx(mask_r);
    assign last       = (mask_r & (mask_r - NREGS'(1))) == '0;
    assign active     = (state == S_ISSUE) || (state == S_WAIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            fault_r <= 1'b0;
            final_r <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                fault_r <= misaligned;
                final_r <= (size == 2'd3) ? blk_final : base;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            write_r <= write;
            size_r  <= size;
            sext_r  <= sign_ext;
            mask_r  <= (size == 2'd3) ? reg_mask : (NREGS'(1) << single_reg);
            addr_r  <= (size == 2'd3) ? blk_first : base;
        end else if (state == S_ISSUE) begin
            data_hold <= store_fmt(size_r, rd_value);
        end else if ((state == S_WAIT) && mem_ready) begin
            mask_r <= mask_r & (mask_r - NREGS'(1));
            addr_r <= addr_r + STEP;
        end
    end

    always_comb begin
        state_nxt   = state;
        rd_idx      = '0;
        wr_en       = 1'b0;
        wr_idx      = '0;
        wr_value    = '0;
        mem_addr    = '0;
        mem_data_wr = '0;
        mem_data_be = '0;
        mem_start   = 1'b0;
        mem_write   = 1'b0;
        busy        = (state != S_IDLE);
        done        = (state == S_DONE);
        fault       = (state == S_DONE) && fault_r;
        final_addr  = final_r;

        case (state)
            S_IDLE:  if (start) state_nxt = (misaligned || empty_blk) ? S_DONE : S_ISSUE;
            S_ISSUE: state_nxt = S_WAIT;
            S_WAIT:  if (mem_ready) state_nxt = last ? S_DONE : S_ISSUE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase

        if (active) begin
            mem_addr    = addr_r[WIDTH-1:2];
            mem_data_be = be_fmt(size_r, addr_r[1:0]);
            mem_write   = write_r;
            mem_start   = (state == S_ISSUE);
            if (write_r) begin
                rd_idx      = cur_idx;
                mem_data_wr = (state == S_ISSUE) ? store_fmt(size_r, rd_value) : data_hold;
            end
        end

        if ((state == S_WAIT) && mem_ready && !write_r) begin
            wr_en    = 1'b1;
            wr_idx   = cur_idx;
            wr_value = load_fmt(size_r, sext_r, addr_r[1:0], mem_data_rd);
        end
    end

endmodule

// File: tb/tb_core_ldst_seq.sv
// Scoreboard bench for core_ldst_seq: directed commands push expected memory
// requests, register writes and completions; a negedge monitor pops and compares.
module tb_core_ldst_seq;

    localparam int WIDTH  = 32;
    localparam int NREGS  = 16;
    localparam int RIDX_W = 4;

    logic              clk = 1'b0;
    logic              rst, start, write, sign_ext, decr, pre;
    logic [1:0]        size;
    logic [WIDTH-1:0]  base;
    logic [NREGS-1:0]  reg_mask;
    logic [RIDX_W-1:0] single_reg, rd_idx, wr_idx;
    logic [WIDTH-1:0]  rd_value, wr_value, mem_data_wr, mem_data_rd, final_addr;
    logic              wr_en, mem_start, mem_write, mem_ready, busy, done, fault;
    logic [WIDTH-3:0]  mem_addr;
    logic [3:0]        mem_data_be;

    logic [WIDTH-1:0]  rf [NREGS];
    assign rd_value = rf[rd_idx];

    always #5 clk = ~clk;

    core_ldst_seq #(.WIDTH(WIDTH), .NREGS(NREGS), .RIDX_W(RIDX_W)) dut (
        .clk(clk), .rst(rst), .start(start), .write(write), .size(size),
        .sign_ext(sign_ext), .base(base), .reg_mask(reg_mask), .single_reg(single_reg),
        .decr(decr), .pre(pre), .rd_idx(rd_idx), .rd_value(rd_value), .wr_en(wr_en),
        .wr_idx(wr_idx), .wr_value(wr_value), .mem_addr(mem_addr), .mem_data_wr(mem_data_wr),
        .mem_data_be(mem_data_be), .mem_start(mem_start), .mem_write(mem_write),
        .mem_ready(mem_ready), .mem_data_rd(mem_data_rd), .busy(busy), .done(done),
        .fault(fault), .final_addr(final_addr)
    );

    // kind 0 = memory request, 1 = register write, 2 = completion
    typedef struct {
        int          kind;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic        d;
    } ev_t;

    ev_t         exp_q[$];
    logic [31:0] rd_q[$];
    ev_t         mon_e;
    int          mon_kind;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          resp_delay = 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic push_req(input logic [31:0] a, input logic [3:0] be, input logic w, input logic [31:0] d);
        ev_t e;
        e.kind = 0; e.a = a; e.b = {28'b0, be}; e.c = d; e.d = w;
        exp_q.push_back(e);
    endtask

    task automatic push_wr(input logic [3:0] idx, input logic [31:0] v);
        ev_t e;
        e.kind = 1; e.a = {28'b0, idx}; e.b = '0; e.c = v; e.d = 1'b0;
        exp_q.push_back(e);
    endtask

    task automatic push_done(input logic [31:0] fa, input logic f);
        ev_t e;
        e.kind = 2; e.a = fa; e.b = '0; e.c = '0; e.d = f;
        exp_q.push_back(e);
    endtask

    // Command inputs are scrambled right after acceptance to expose missing latches.
    task automatic issue(input logic w, input logic [1:0] sz, input logic sx, input logic [31:0] b,
                         input logic [15:0] m, input logic [3:0] sr, input logic dc, input logic pr);
        @(posedge clk); #1;
        start = 1'b1; write = w; size = sz; sign_ext = sx; base = b;
        reg_mask = m; single_reg = sr; decr = dc; pre = pr;
        @(posedge clk); #1;
        start = 1'b0; write = ~w; size = ~sz; sign_ext = ~sx; base = ~b;
        reg_mask = ~m; single_reg = ~sr; decr = ~dc; pre = ~pr;
    endtask

    // Counts cycles from acceptance to done; optionally strobes start mid-flight.
    task automatic wait_done(input string name, input int exp_lat, input int poke_at);
        int c;
        c = 1;
        forever begin
            @(negedge clk);
            if (done || c >= 60) break;
            start = (c == poke_at);
            c++;
        end
        start = 1'b0;
        if (!done) chk({name, "_timeout"}, 32'(c), 32'(exp_lat));
        else       chk({name, "_latency"}, 32'(c), 32'(exp_lat));
        @(posedge clk); #1;
    endtask

    // Memory responder: returns mem_ready resp_delay cycles after the request cycle.
    initial begin
        mem_ready   = 1'b0;
        mem_data_rd = '0;
        forever begin
            @(negedge clk);
            if (mem_start) begin
                repeat (resp_delay) @(posedge clk);
                #1;
                mem_ready   = 1'b1;
                mem_data_rd = (rd_q.size() != 0) ? rd_q.pop_front() : 32'h0;
                @(posedge clk); #1;
                mem_ready   = 1'b0;
                mem_data_rd = '0;
            end
        end
    end

    always @(negedge clk) begin
        if (fault && !done) chk("stray_fault", 32'(fault), 32'd0);
        if (mem_start || wr_en || done) begin
            mon_kind = mem_start ? 0 : (wr_en ? 1 : 2);
            if (exp_q.size() == 0) begin
                chk("unexpected_event", {29'b0, mem_start, wr_en, done}, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("event_kind", 32'(mon_kind), 32'(mon_e.kind));
                chk("busy_during_event", 32'(busy), 32'd1);
                if (mon_kind == mon_e.kind) begin
                    case (mon_kind)
                        0: begin
                            chk("req_addr", 32'(mem_addr), mon_e.a);
                            chk("req_be", 32'(mem_data_be), mon_e.b);
                            chk("req_write", 32'(mem_write), 32'(mon_e.d));
                            if (mon_e.d) chk("req_data", mem_data_wr, mon_e.c);
                        end
                        1: begin
                            chk("wr_idx", 32'(wr_idx), mon_e.a);
                            chk("wr_value", wr_value, mon_e.c);
                        end
                        default: begin
                            chk("done_fault", 32'(fault), 32'(mon_e.d));
                            chk("final_addr", final_addr, mon_e.a);
                        end
                    endcase
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < NREGS; i++) rf[i] = 32'h0;
        rf[0] = 32'hDEAD0000;
        rf[1] = 32'h0000BEEF;
        rf[3] = 32'h1234ABCD;
        rst = 1'b1; start = 1'b0; write = 1'b0; size = 2'd0; sign_ext = 1'b0;
        base = '0; reg_mask = '0; single_reg = '0; decr = 1'b0; pre = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_mem_start", 32'(mem_start), 32'd0);
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_final_addr", final_addr, 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_be", 32'(mem_data_be), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Signed byte load from the top lane.
        rd_q.push_back(32'h80000000);
        push_req(32'h400, 4'b1000, 1'b0, 32'h0);
        push_wr(4'd5, 32'hFFFFFF80);
        push_done(32'h1003, 1'b0);
        issue(1'b0, 2'd0, 1'b1, 32'h1003, 16'h0, 4'd5, 1'b0, 1'b0);
        wait_done("ldb_sext", 3, 0);

        // Half store into the upper pair.
        push_req(32'h800, 4'b1100, 1'b1, 32'hABCDABCD);
        push_done(32'h2002, 1'b0);
        issue(1'b1, 2'd1, 1'b0, 32'h2002, 16'h0, 4'd3, 1'b0, 1'b0);
        wait_done("sth", 3, 0);

        // Ascending block load, with an ignored start strobe mid-transfer.
        rd_q.push_back(32'h11111111);
        rd_q.push_back(32'h22222222);
        rd_q.push_back(32'h33333333);
        push_req(32'h40, 4'hF, 1'b0, 32'h0);
        push_wr(4'd0, 32'h11111111);
        push_req(32'h41, 4'hF, 1'b0, 32'h0);
        push_wr(4'd2, 32'h22222222);
        push_req(32'h42, 4'hF, 1'b0, 32'h0);
        push_wr(4'd15, 32'h33333333);
        push_done(32'h10C, 1'b0);
        issue(1'b0, 2'd3, 1'b0, 32'h100, 16'h8005, 4'd0, 1'b0, 1'b0);
        wait_done("blk_ld_asc", 7, 2);

        // Descending pre-decrement block store.
        push_req(32'h3E, 4'hF, 1'b1, 32'hDEAD0000);
        push_req(32'h3F, 4'hF, 1'b1, 32'h0000BEEF);
        push_done(32'hF8, 1'b0);
        issue(1'b1, 2'd3, 1'b0, 32'h100, 16'h0003, 4'd0, 1'b1, 1'b1);
        wait_done("blk_st_desc", 5, 0);

        // Misaligned word load and empty block complete at once with no request.
        push_done(32'h102, 1'b1);
        issue(1'b0, 2'd2, 1'b0, 32'h102, 16'h0, 4'd2, 1'b0, 1'b0);
        wait_done("ldw_misaligned", 1, 0);

        push_done(32'h200, 1'b0);
        issue(1'b0, 2'd3, 1'b0, 32'h200, 16'h0, 4'd0, 1'b0, 1'b0);
        wait_done("blk_empty", 1, 0);

        push_done(32'h2001, 1'b1);
        issue(1'b1, 2'd1, 1'b0, 32'h2001, 16'h0, 4'd1, 1'b0, 1'b0);
        wait_done("sth_misaligned", 1, 0);

        // Zero-extended half load from the upper half.
        rd_q.push_back(32'h87654321);
        push_req(32'h800, 4'b1100, 1'b0, 32'h0);
        push_wr(4'd7, 32'h00008765);
        push_done(32'h2002, 1'b0);
        issue(1'b0, 2'd1, 1'b0, 32'h2002, 16'h0, 4'd7, 1'b0, 1'b0);
        wait_done("ldh_zext", 3, 0);

        // Signed byte load of a positive value from lane 1.
        rd_q.push_back(32'h00007F00);
        push_req(32'h400, 4'b0010, 1'b0, 32'h0);
        push_wr(4'd9, 32'h0000007F);
        push_done(32'h1001, 1'b0);
        issue(1'b0, 2'd0, 1'b1, 32'h1001, 16'h0, 4'd9, 1'b0, 1'b0);
        wait_done("ldb_pos", 3, 0);

        // Byte store replicates the low byte.
        push_req(32'hC00, 4'b0010, 1'b1, 32'hEFEFEFEF);
        push_done(32'h3001, 1'b0);
        issue(1'b1, 2'd0, 1'b0, 32'h3001, 16'h0, 4'd1, 1'b0, 1'b0);
        wait_done("stb", 3, 0);

        // Descending block from address 0 wraps around.
        rd_q.push_back(32'hCAFEF00D);
        push_req(32'h3FFFFFFF, 4'hF, 1'b0, 32'h0);
        push_wr(4'd0, 32'hCAFEF00D);
        push_done(32'hFFFFFFFC, 1'b0);
        issue(1'b0, 2'd3, 1'b0, 32'h0, 16'h0001, 4'd0, 1'b1, 1'b1);
        wait_done("blk_wrap", 3, 0);

        // Reset while waiting; the late response must not write a register.
        resp_delay = 2;
        rd_q.push_back(32'hFFFFFFFF);
        push_req(32'h140, 4'hF, 1'b0, 32'h0);
        issue(1'b0, 2'd2, 1'b0, 32'h500, 16'h0, 4'd4, 1'b0, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_ready_seen", 32'(mem_ready), 32'd1);
        chk("rst_mid_wr_en", 32'(wr_en), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        resp_delay = 1;

        rd_q.push_back(32'h0BADBEEF);
        push_req(32'h141, 4'hF, 1'b0, 32'h0);
        push_wr(4'd6, 32'h0BADBEEF);
        push_done(32'h504, 1'b0);
        issue(1'b0, 2'd2, 1'b0, 32'h504, 16'h0, 4'd6, 1'b0, 1'b0);
        wait_done("ldw_after_rst", 3, 0);

        repeat (3) @(posedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
